// File: rtl/lemming_dig_arbiter.sv
// rtl/lemming_dig_arbiter.sv - round-robin shovel arbiter for four lemmings
// Moore FSM: grant, wait for digging ack, hold with a dig limit, one-cycle release.
module lemming_dig_arbiter #(
  parameter int ACK_WAIT = 4,
  parameter int MAX_DIG  = 64
) (
  input  logic       clk,
  input  logic       areset,
  input  logic [3:0] req,
  input  logic [3:0] digging,
  output logic [3:0] dig_grant,
  output logic [1:0] owner,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [15:0] ACK_LAST = 16'(ACK_WAIT - 1);
  localparam logic [15:0] DIG_LAST = 16'(MAX_DIG - 1);

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [15:0] wait_q, wait_d;
  logic [15:0] hold_q, hold_d;
  logic        to_q, to_d;
  logic [1:0]  chosen;
  logic [1:0]  cand;

  // Scan from farthest to nearest so the requester closest after ptr wins.
  always_comb begin
    chosen = 2'd0;
    cand   = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      cand = ptr_q + 2'(i);
      if (req[cand]) chosen = cand;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    wait_d  = wait_q;
    hold_d  = hold_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          owner_d = chosen;
          wait_d  = 16'd0;
        end
      end
      GRANT: begin
        if (digging[owner_q]) begin
          state_d = HOLD;
          hold_d  = 16'd0;
        end else if (!req[owner_q]) begin
          state_d = RELEASE;
        end else if (wait_q == ACK_LAST) begin
          state_d = RELEASE;
          to_d    = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      HOLD: begin
        if (!digging[owner_q]) begin
          state_d = RELEASE;
        end else if (hold_q == DIG_LAST) begin
          state_d = RELEASE;
          to_d    = 1'b1;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        ptr_d   = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd3;
      wait_q  <= 16'd0;
      hold_q  <= 16'd0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      wait_q  <= wait_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
    end
  end

  assign busy      = (state_q == GRANT) || (state_q == HOLD);
  assign dig_grant = busy ? (4'b0001 << owner_q) : 4'b0000;
  assign owner     = owner_q;
  assign timeout   = (state_q == RELEASE) && to_q;

endmodule

// File: tb/tb_lemming_dig_arbiter.sv
// tb/tb_lemming_dig_arbiter.sv - scoreboard bench for lemming_dig_arbiter
module tb_lemming_dig_arbiter;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] digging = 4'b0000;
  logic [3:0] dig_grant;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;

  typedef struct {
    logic [3:0] g;
    logic       to;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  always #5 clk = ~clk;

  lemming_dig_arbiter #(.ACK_WAIT(4), .MAX_DIG(64)) dut (
    .clk       (clk),
    .areset    (areset),
    .req       (req),
    .digging   (digging),
    .dig_grant (dig_grant),
    .owner     (owner),
    .busy      (busy),
    .timeout   (timeout)
  );

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic step(input logic [3:0] r, input logic [3:0] d,
                      input logic [3:0] g, input logic to);
    exp_t e;
    req     = r;
    digging = d;
    @(posedge clk);
    e.g  = g;
    e.to = to;
    e.id = step_id;
    step_id++;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", name, got, want);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (dig_grant !== e.g || busy !== (e.g != 4'b0000) || timeout !== e.to ||
          (e.g != 4'b0000 && owner !== idx_of(e.g))) begin
        errors++;
        $display("FAIL step%0d grant=%b busy=%b timeout=%b owner=%0d expected grant=%b timeout=%b",
                 e.id, dig_grant, busy, timeout, owner, e.g, e.to);
      end
    end else if (!areset && (dig_grant != 4'b0000 || timeout)) begin
      errors++;
      $display("FAIL unexpected_output grant=%b timeout=%b expected grant=0000 timeout=0",
               dig_grant, timeout);
    end
  end

  always @(negedge clk) begin
    assert ($onehot0(dig_grant) && (busy == (dig_grant != 4'b0000)))
    else begin
      errors++;
      $display("FAIL onehot_busy grant=%b busy=%b", dig_grant, busy);
    end
  end

  initial begin
    #1;
    check("reset_async", {dig_grant, owner, busy, timeout}, 8'b0);
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;

    // Round robin with every request held: 0,1,2,3,0 with two idle cycles apart.
    for (int k = 0; k < 5; k++) begin
      logic [3:0] g;
      logic [3:0] r_end;
      g     = 4'b0001 << (k % 4);
      r_end = (k == 4) ? 4'b0000 : 4'b1111;
      step(4'b1111, 4'b0000, g, 1'b0);
      step(4'b1111, ~g,      g, 1'b0);
      step(4'b1111, g,       g, 1'b0);
      step(4'b1111, g,       g, 1'b0);
      step(r_end,   4'b0000, 4'b0000, 1'b0);
      step(r_end,   4'b0000, 4'b0000, 1'b0);
    end
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Acknowledge timeout for lemming 2, then re-grant.
    repeat (4) step(4'b0100, 4'b1011, 4'b0100, 1'b0);
    step(4'b0100, 4'b0000, 4'b0000, 1'b1);
    step(4'b0100, 4'b0000, 4'b0000, 1'b0);
    step(4'b0100, 4'b0000, 4'b0100, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Lemming 1 digs until MAX_DIG expiry; lemming 2 is next in rotation.
    step(4'b0010, 4'b0000, 4'b0010, 1'b0);
    step(4'b0110, 4'b0010, 4'b0010, 1'b0);
    repeat (63) step(4'b0110, 4'b0010, 4'b0010, 1'b0);
    step(4'b0110, 4'b0010, 4'b0000, 1'b1);
    step(4'b0110, 4'b0000, 4'b0000, 1'b0);
    step(4'b0110, 4'b0000, 4'b0100, 1'b0);

    // Reset while lemming 2 holds the shovel.
    step(4'b0110, 4'b0100, 4'b0100, 1'b0);
    step(4'b0110, 4'b0100, 4'b0100, 1'b0);
    @(negedge clk);
    #1 areset = 1'b1;
    #1 check("reset_mid_hold", {4'b0000, dig_grant, busy, timeout, 2'b00}, 8'b0);
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    step(4'b0110, 4'b0000, 4'b0010, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Lemming 3 stops on the very cycle the hold limit is reached: no timeout.
    step(4'b1000, 4'b0000, 4'b1000, 1'b0);
    step(4'b1000, 4'b1000, 4'b1000, 1'b0);
    repeat (63) step(4'b1000, 4'b1000, 4'b1000, 1'b0);
    step(4'b1000, 4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lemming_dig_arbiter.md
LEMMING_DIG_ARBITER -- requirements
Module: lemming_dig_arbiter

Interface
REQ-001 Parameter ACK_WAIT, default 4: cycles a granted lemming has to raise digging before the grant is withdrawn; legal range 1..65535.
REQ-002 Parameter MAX_DIG, default 64: maximum cycles one owner holds the shovel before a forced revoke; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 areset  input  1  asynchronous, active-high reset.
REQ-005 req  input  4  per-lemming dig request; bit i belongs to lemming i.
REQ-006 digging  input  4  per-lemming digging status, fed back from the lemming controllers.
REQ-007 dig_grant  output  4  one-hot or zero shovel grant; bit i drives the dig input of lemming i.
REQ-008 owner  output  2  index of the current grant holder; meaningful only while busy=1.
REQ-009 busy  output  1  high while the shovel is granted (states GRANT and HOLD).
REQ-010 timeout  output  1  one-cycle pulse marking a revoke caused by ACK_WAIT or MAX_DIG expiry.

Function
REQ-011 States SHALL be IDLE, GRANT, HOLD and RELEASE; all outputs SHALL be decoded from registered state, owner and flag (Moore), with no input-to-output combinational path.
REQ-012 Rotating pointer ptr[1:0] SHALL hold the last owner; in IDLE, the requester chosen SHALL be the first set bit of req scanning ptr+1, ptr+2, ptr+3, ptr+4 (mod 4).
REQ-013 IDLE: if any req bit is set, go to GRANT with owner=chosen index and wait counter=0; otherwise stay in IDLE.
REQ-014 Grant latency SHALL be exactly 1 cycle: req sampled at edge t gives dig_grant[owner]=1 from edge t+1.
REQ-015 GRANT: dig_grant = 1<<owner; the wait counter increments each cycle.
REQ-016 GRANT exits, in priority order:
  - digging[owner]=1: go to HOLD, hold counter=0.
  - req[owner]=0: go to RELEASE, no timeout.
  - wait counter = ACK_WAIT-1: go to RELEASE with timeout.
  - otherwise stay in GRANT.
REQ-017 HOLD: dig_grant = 1<<owner; the hold counter increments each cycle.
REQ-018 HOLD exits, in priority order:
  - digging[owner]=0 (lemming fell or stopped): go to RELEASE, no timeout.
  - hold counter = MAX_DIG-1: go to RELEASE with timeout.
  - otherwise stay in HOLD.
REQ-019 RELEASE SHALL last exactly one cycle, with dig_grant=0 and busy=0; ptr SHALL load owner; the next state SHALL be IDLE.
REQ-020 timeout SHALL be 1 exactly during a RELEASE cycle entered by counter expiry, and 0 at all other times.
REQ-021 Counters SHALL be 16 bits, compared with equality only, and SHALL never wrap within a state, because parameters are limited to 65535.
REQ-022 While busy, req and digging bits of non-owners SHALL be ignored, and those requests SHALL not be latched.
REQ-023 Minimum spacing between two grants SHALL be 2 cycles of dig_grant=0: the RELEASE cycle plus the IDLE cycle.
REQ-024 At most one dig_grant bit SHALL be high in any cycle.
REQ-025 No other states SHALL exist; any unreachable encoding SHALL return to IDLE on the next edge.

Reset
REQ-026 areset=1 SHALL immediately force state=IDLE, ptr=3, owner=0, both counters=0, dig_grant=0, busy=0 and timeout=0, without waiting for a clock edge.
REQ-027 Reset asserted mid-GRANT or mid-HOLD SHALL drop dig_grant within the same cycle, and no timeout pulse SHALL follow.
REQ-028 After reset release, the first grant SHALL favour lemming 0 when several requests are pending, because ptr=3.

Verification
REQ-029 Reset, then req=4'b1111 held -> grants in order 0,1,2,3,0, each with 2 idle cycles between them, when each owner's digging follows its grant.
REQ-030 req=4'b0100, digging never raised -> dig_grant=4'b0100 for 4 cycles, then RELEASE with timeout=1 for 1 cycle, then IDLE, then a re-grant to lemming 2.
REQ-031 Owner 1 in HOLD with digging[1] held high -> dig_grant=4'b0010 for exactly 1 GRANT cycle plus 64 HOLD cycles, then timeout pulse; ptr=1, so the next grant goes to lemming 2 if requesting.
REQ-032 Owner 3 in HOLD, digging[3] falls on the same edge the hold counter reaches 63 -> RELEASE with timeout=0.
REQ-033 areset pulsed while owner 2 is in HOLD -> dig_grant=0 and busy=0 immediately, timeout=0; with req=4'b0110 afterwards, the first grant goes to lemming 1.
REQ-034 Throughout all scenarios, an assertion SHALL check that dig_grant is onehot0 and that busy equals (dig_grant != 0).
